// File: rtl/conv_cfg_pkg.sv
// Geometry helpers and FSM state encoding shared by the
// convolution tile scheduler and its index counter.
package conv_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WGT,
      S_IFM,
      S_CMP,
      S_ST,
      S_NEXT,
      S_FIN
   } state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int ofm_size_f(input int ifm, input int k);
      return ifm - k + 1;
   endfunction

   function automatic int ofm_size_pooling_f(input int ifm, input int k);
      return ofm_size_f(ifm, k) / 2;
   endfunction

   function automatic int no_tiling_per_line_f(
      input int ifm,
      input int k,
      input int ss
   );
      return ceil_div(ofm_size_f(ifm, k), ss);
   endfunction

   function automatic int no_tiling_f(
      input int ifm,
      input int k,
      input int ss
   );
      return ofm_size_f(ifm, k) * no_tiling_per_line_f(ifm, k, ss);
   endfunction

   function automatic int no_fg_f(input int nf, input int ss);
      return ceil_div(nf, ss);
   endfunction

   // Last tile of a row may be narrower than the array edge.
   function automatic int tile_width_f(
      input int ofm,
      input int ss,
      input int col
   );
      int rem;
      rem = ofm - col * ss;
      return (rem < ss) ? rem : ss;
   endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested column / row / filter-group counters with wrap flags
// and the registered width of the current tile.
module tile_index_counter
   import conv_cfg_pkg::*;
#(
   parameter int SYSTOLIC_SIZE      = 16,
   parameter int OFM_SIZE           = 32,
   parameter int NO_TILING_PER_LINE = 2,
   parameter int NO_FG              = 1,
   parameter int FG_W               = 1,
   parameter int ROW_W              = 6,
   parameter int COL_W              = 2,
   parameter int TW_W               = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [FG_W-1:0]  filter_group,
   output logic [ROW_W-1:0] tile_row,
   output logic [COL_W-1:0] tile_col,
   output logic [TW_W-1:0]  tile_width,
   output logic             col_wrap,
   output logic             row_wrap,
   output logic             fg_last
);

   localparam logic [TW_W-1:0] W_FIRST =
      TW_W'(tile_width_f(OFM_SIZE, SYSTOLIC_SIZE, 0));

   logic [COL_W-1:0] col_nxt;
   logic [TW_W-1:0]  width_nxt;

   assign col_wrap = (tile_col == COL_W'(NO_TILING_PER_LINE - 1));
   assign row_wrap = (tile_row == ROW_W'(OFM_SIZE - 1));
   assign fg_last  = (filter_group == FG_W'(NO_FG - 1));

   always_comb begin
      col_nxt   = tile_col + COL_W'(1);
      width_nxt = TW_W'(tile_width_f(OFM_SIZE, SYSTOLIC_SIZE,
                                     int'(col_nxt)));
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         filter_group <= '0;
         tile_row     <= '0;
         tile_col     <= '0;
         tile_width   <= W_FIRST;
      end else if (adv) begin
         if (col_wrap) begin
            tile_col   <= '0;
            tile_width <= W_FIRST;
            if (row_wrap) begin
               tile_row     <= '0;
               filter_group <= fg_last ? '0
                             : filter_group + FG_W'(1);
            end else begin
               tile_row <= tile_row + ROW_W'(1);
            end
         end else begin
            tile_col   <= col_nxt;
            tile_width <= width_nxt;
         end
      end
   end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: walks filter groups and OFM tiles, issuing
// weight / IFM / compute / store handshakes in order.
module conv_tile_scheduler
   import conv_cfg_pkg::*;
#(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int IFM_SIZE      = 34,
   parameter int IFM_CHANNEL   = 3,
   parameter int KERNEL_SIZE   = 3,
   parameter int NO_FILTER     = 16,
   localparam int OFM_SIZE = ofm_size_f(IFM_SIZE, KERNEL_SIZE),
   localparam int NO_TILING_PER_LINE =
      no_tiling_per_line_f(IFM_SIZE, KERNEL_SIZE, SYSTOLIC_SIZE),
   localparam int NO_FG = no_fg_f(NO_FILTER, SYSTOLIC_SIZE),
   localparam int FG_W  = $clog2(NO_FG) + 1,
   localparam int ROW_W = $clog2(OFM_SIZE) + 1,
   localparam int COL_W = $clog2(NO_TILING_PER_LINE) + 1,
   localparam int TW_W  = $clog2(SYSTOLIC_SIZE) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             done,
   output logic             busy,
   output logic             wgt_req,
   input  logic             wgt_ack,
   output logic             ifm_req,
   input  logic             ifm_ack,
   output logic             cmp_req,
   input  logic             cmp_ack,
   output logic             st_req,
   input  logic             st_ack,
   output logic [FG_W-1:0]  filter_group,
   output logic [ROW_W-1:0] tile_row,
   output logic [COL_W-1:0] tile_col,
   output logic [TW_W-1:0]  tile_width
);

   // Channel count only matters to the loaders.
   if (IFM_CHANNEL < 1) begin : g_no_channels
   end

   state_t state;
   logic   clr;
   logic   adv;
   logic   col_wrap;
   logic   row_wrap;
   logic   fg_last;

   assign clr = (state == S_IDLE) && start;
   assign adv = (state == S_NEXT);

   tile_index_counter #(
      .SYSTOLIC_SIZE      (SYSTOLIC_SIZE),
      .OFM_SIZE           (OFM_SIZE),
      .NO_TILING_PER_LINE (NO_TILING_PER_LINE),
      .NO_FG              (NO_FG),
      .FG_W               (FG_W),
      .ROW_W              (ROW_W),
      .COL_W              (COL_W),
      .TW_W               (TW_W)
   ) u_idx (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .adv          (adv),
      .filter_group (filter_group),
      .tile_row     (tile_row),
      .tile_col     (tile_col),
      .tile_width   (tile_width),
      .col_wrap     (col_wrap),
      .row_wrap     (row_wrap),
      .fg_last      (fg_last)
   );

   // Each req is raised one cycle into its state so an ack only
   // counts once the req is already registered high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         wgt_req <= 1'b0;
         ifm_req <= 1'b0;
         cmp_req <= 1'b0;
         st_req  <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_WGT;
                  busy  <= 1'b1;
               end
            end
            S_WGT: begin
               if (!wgt_req) begin
                  wgt_req <= 1'b1;
               end else if (wgt_ack) begin
                  wgt_req <= 1'b0;
                  state   <= S_IFM;
               end
            end
            S_IFM: begin
               if (!ifm_req) begin
                  ifm_req <= 1'b1;
               end else if (ifm_ack) begin
                  ifm_req <= 1'b0;
                  state   <= S_CMP;
               end
            end
            S_CMP: begin
               if (!cmp_req) begin
                  cmp_req <= 1'b1;
               end else if (cmp_ack) begin
                  cmp_req <= 1'b0;
                  state   <= tile_row[0] ? S_ST : S_NEXT;
               end
            end
            S_ST: begin
               if (!st_req) begin
                  st_req <= 1'b1;
               end else if (st_ack) begin
                  st_req <= 1'b0;
                  state  <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (col_wrap && row_wrap && fg_last) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end else if (col_wrap && row_wrap) begin
                  state <= S_WGT;
               end else begin
                  state <= S_IFM;
               end
            end
            S_FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench: three scheduler configs, handshake responders and a
// queue-based model of the expected handshake sequence.
module tb_conv_tile_scheduler;

   localparam int NI = 3;

   typedef struct {
      int kind;
      int fg;
      int row;
      int col;
      int w;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rnd_mode = 1'b0;
   logic       start [NI] = '{default: 1'b0};
   logic       done_v [NI];
   logic       busy_v [NI];
   logic [3:0] req_v [NI];
   logic [3:0] ack_v [NI];
   int         fg_v [NI];
   int         row_v [NI];
   int         col_v [NI];
   int         tw_v [NI];

   int   errors = 0;
   int   checks = 0;
   ev_t  exp_q [NI][$];
   logic model_busy [NI] = '{default: 1'b0};
   logic prev_any [NI] = '{default: 1'b0};
   logic seen_ifm [NI] = '{default: 1'b0};
   int   snap [NI][4];
   int   hs_cnt [NI][4];
   int   done_cnt [NI];
   int   first_ifm [NI][3];
   int   last_cmp [NI][4];

   always #5 clk = ~clk;

   function automatic int cfg_ifm(input int g);
      return (g == 1) ? 20 : 34;
   endfunction

   function automatic int cfg_nf(input int g);
      return (g == 2) ? 40 : 16;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int IFMS = (g == 1) ? 20 : 34;
      localparam int NF   = (g == 2) ? 40 : 16;
      localparam int OFM  = IFMS - 2;
      localparam int NT   = (OFM + 15) / 16;
      localparam int NFG  = (NF + 15) / 16;

      logic [$clog2(NFG):0] fg_l;
      logic [$clog2(OFM):0] row_l;
      logic [$clog2(NT):0]  col_l;
      logic [4:0]           tw_l;
      logic [3:0]           req_l;
      logic [3:0]           ack_l = 4'b0;
      int                   dly [4] = '{default: 0};

      conv_tile_scheduler #(
         .SYSTOLIC_SIZE (16),
         .IFM_SIZE      (IFMS),
         .IFM_CHANNEL   (3),
         .KERNEL_SIZE   (3),
         .NO_FILTER     (NF)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .start        (start[g]),
         .done         (done_v[g]),
         .busy         (busy_v[g]),
         .wgt_req      (req_l[0]),
         .wgt_ack      (ack_l[0]),
         .ifm_req      (req_l[1]),
         .ifm_ack      (ack_l[1]),
         .cmp_req      (req_l[2]),
         .cmp_ack      (ack_l[2]),
         .st_req       (req_l[3]),
         .st_ack       (ack_l[3]),
         .filter_group (fg_l),
         .tile_row     (row_l),
         .tile_col     (col_l),
         .tile_width   (tw_l)
      );

      assign req_v[g] = req_l;
      assign ack_v[g] = ack_l;
      assign fg_v[g]  = int'(fg_l);
      assign row_v[g] = int'(row_l);
      assign col_v[g] = int'(col_l);
      assign tw_v[g]  = int'(tw_l);

      // Ack after a delay; in random mode also toggle acks
      // spuriously while the matching req is low.
      always @(posedge clk) begin
         for (int k = 0; k < 4; k++) begin
            if (rst) begin
               ack_l[k] <= 1'b0;
            end else if (req_l[k] && ack_l[k]) begin
               ack_l[k] <= 1'b0;
            end else if (req_l[k]) begin
               if (dly[k] == 0) ack_l[k] <= 1'b1;
               else dly[k] <= dly[k] - 1;
            end else if (g == 0 && rnd_mode) begin
               dly[k]   <= int'($urandom_range(0, 20));
               ack_l[k] <= ($urandom_range(0, 3) == 0);
            end else begin
               dly[k]   <= 0;
               ack_l[k] <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected handshake list for one whole layer.
   task automatic build(input int g);
      int ofm, nt, nfg, w;
      ofm = cfg_ifm(g) - 3 + 1;
      nt  = (ofm + 15) / 16;
      nfg = (cfg_nf(g) + 15) / 16;
      exp_q[g].delete();
      for (int f = 0; f < nfg; f++)
         for (int r = 0; r < ofm; r++)
            for (int c = 0; c < nt; c++) begin
               w = (ofm - c * 16 < 16) ? ofm - c * 16 : 16;
               if (r == 0 && c == 0)
                  exp_q[g].push_back('{0, f, r, c, w});
               exp_q[g].push_back('{1, f, r, c, w});
               exp_q[g].push_back('{2, f, r, c, w});
               if (r % 2 == 1)
                  exp_q[g].push_back('{3, f, r, c, w});
            end
   endtask

   task automatic check_inst(input int g);
      logic       mb;
      logic [3:0] hs;
      int         k;
      ev_t        e;
      mb = model_busy[g];
      chk($sformatf("i%0d busy", g), busy_v[g], mb);
      if (req_v[g] != 4'b0) begin
         chk($sformatf("i%0d req onehot", g), $onehot(req_v[g]), 1);
         if (prev_any[g]) begin
            chk($sformatf("i%0d fg stable", g), fg_v[g], snap[g][0]);
            chk($sformatf("i%0d row stable", g), row_v[g], snap[g][1]);
            chk($sformatf("i%0d col stable", g), col_v[g], snap[g][2]);
            chk($sformatf("i%0d tw stable", g), tw_v[g], snap[g][3]);
         end else begin
            snap[g] = '{fg_v[g], row_v[g], col_v[g], tw_v[g]};
         end
      end
      prev_any[g] = (req_v[g] != 4'b0);
      hs = req_v[g] & ack_v[g];
      if (hs != 4'b0) begin
         k = 0;
         for (int b = 0; b < 4; b++) if (hs[b]) k = b;
         hs_cnt[g][k]++;
         chk($sformatf("i%0d handshake expected", g),
             exp_q[g].size() > 0, 1);
         if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            chk($sformatf("i%0d hs kind", g), k, e.kind);
            chk($sformatf("i%0d hs fg", g), fg_v[g], e.fg);
            chk($sformatf("i%0d hs row", g), row_v[g], e.row);
            chk($sformatf("i%0d hs col", g), col_v[g], e.col);
            chk($sformatf("i%0d hs width", g), tw_v[g], e.w);
         end
         if (k == 1 && !seen_ifm[g]) begin
            seen_ifm[g]  = 1'b1;
            first_ifm[g] = '{fg_v[g], row_v[g], col_v[g]};
         end
         if (k == 2)
            last_cmp[g] = '{fg_v[g], row_v[g], col_v[g], tw_v[g]};
      end
      if (done_v[g]) begin
         done_cnt[g]++;
         chk($sformatf("i%0d done left", g), exp_q[g].size(), 0);
         model_busy[g] = 1'b0;
      end
      if (start[g] && !mb) begin
         model_busy[g] = 1'b1;
         build(g);
         hs_cnt[g]   = '{0, 0, 0, 0};
         done_cnt[g] = 0;
         seen_ifm[g] = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (rst) begin
               model_busy[g] = 1'b0;
               prev_any[g]   = 1'b0;
               exp_q[g].delete();
            end else begin
               check_inst(g);
            end
         end
      end
   end

   function automatic logic any_busy();
      return busy_v[0] | busy_v[1] | busy_v[2];
   endfunction

   task automatic wait_idle(input string nm, input int limit);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (any_busy() && n < limit);
      chk($sformatf("%s finished", nm), any_busy(), 0);
   endtask

   task automatic wait_sig(input string nm, input int g, input int b,
                           input int limit);
      int n;
      n = 0;
      while (!(b < 4 ? req_v[g][b] : done_v[g]) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("%s reached", nm),
          (b < 4 ? req_v[g][b] : done_v[g]), 1);
   endtask

   task automatic pulse_start(input int g);
      @(posedge clk);
      #1 start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, " req"}, req_v[0], 0);
      chk({nm, " busy"}, busy_v[0], 0);
      chk({nm, " done"}, done_v[0], 0);
      chk({nm, " fg"}, fg_v[0], 0);
      chk({nm, " row"}, row_v[0], 0);
      chk({nm, " col"}, col_v[0], 0);
      chk({nm, " width"}, tw_v[0], 16);
   endtask

   task automatic check_default_layer(input string nm);
      chk({nm, " wgt count"}, hs_cnt[0][0], 1);
      chk({nm, " ifm count"}, hs_cnt[0][1], 64);
      chk({nm, " cmp count"}, hs_cnt[0][2], 64);
      chk({nm, " st count"}, hs_cnt[0][3], 32);
      chk({nm, " done count"}, done_cnt[0], 1);
      chk({nm, " last row"}, last_cmp[0][1], 31);
      chk({nm, " last col"}, last_cmp[0][2], 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("reset");
      chk("reset i1 width", tw_v[1], 16);

      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) start[g] = 1'b1;
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) start[g] = 1'b0;
      wait_idle("base", 5000);
      check_default_layer("base");
      chk("base first fg", first_ifm[0][0], 0);
      chk("base first row", first_ifm[0][1], 0);
      chk("base first col", first_ifm[0][2], 0);
      chk("ifm20 cmp count", hs_cnt[1][2], 36);
      chk("ifm20 st count", hs_cnt[1][3], 18);
      chk("ifm20 last width", last_cmp[1][3], 2);
      chk("nf40 wgt count", hs_cnt[2][0], 3);
      chk("nf40 cmp count", hs_cnt[2][2], 192);
      chk("nf40 last fg", last_cmp[2][0], 2);

      rnd_mode = 1'b1;
      pulse_start(0);
      wait_idle("random", 20000);
      rnd_mode = 1'b0;
      check_default_layer("random");

      pulse_start(0);
      wait_sig("cmp req", 0, 2, 100);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      wait_sig("done", 0, 4, 5000);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("ignored start busy", busy_v[0], 0);
      check_default_layer("ignored start");

      pulse_start(0);
      wait_sig("st req", 0, 3, 200);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("mid rst");
      pulse_start(0);
      wait_idle("after rst", 5000);
      check_default_layer("after rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Top-level sequencer for the 16x16 systolic convolution + 2x2 max-pool datapath. It walks filter groups and output tiles and issues a request/acknowledge handshake to the weight loader, the IFM loader, the systolic compute core and the pooled-OFM store unit, in that order. It also drives the current tile coordinates those units use for addressing. It sits between the external `start`/`done` pins and the datapath units, replacing ad-hoc sequencing inside the main control.

## Interface
- SYSTOLIC_SIZE, 16, array edge; the number of OFM columns per tile and the number of filters per group
- IFM_SIZE, 34, input feature map height/width
- IFM_CHANNEL, 3, input channels; passed to the loaders as a count only
- KERNEL_SIZE, 3, square kernel edge
- NO_FILTER, 16, total output filters
- clk  in  1  the single clock
- rst  in  1  one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse; begins a layer when idle
- done  out  1  one-cycle pulse when the last store completes
- busy  out  1  high from the cycle after an accepted `start` through the `done` cycle
- wgt_req / wgt_ack  out / in  1 / 1  load weights for `filter_group`
- ifm_req / ifm_ack  out / in  1 / 1  load IFM window for (`tile_row`, `tile_col`)
- cmp_req / cmp_ack  out / in  1 / 1  run the systolic pass for the current tile
- st_req / st_ack  out / in  1 / 1  pool and store the row pair ending at `tile_row`
- filter_group  out  $clog2(NO_FG)+1  current filter group
- tile_row  out  $clog2(OFM_SIZE)+1  OFM row of the tile
- tile_col  out  $clog2(NO_TILING_PER_LINE)+1  tile index within the row
- tile_width  out  $clog2(SYSTOLIC_SIZE)+1  valid columns in the tile (1..SYSTOLIC_SIZE)

## Operation
- Derived values:
  - OFM_SIZE = IFM_SIZE-KERNEL_SIZE+1
  - NO_TILING_PER_LINE = ceil(OFM_SIZE/SYSTOLIC_SIZE)
  - NO_FG = ceil(NO_FILTER/SYSTOLIC_SIZE)
  - tile_width = min(SYSTOLIC_SIZE, OFM_SIZE - tile_col*SYSTOLIC_SIZE)
- FSM states: IDLE, WGT, IFM, CMP, ST, NEXT, FIN.
- State transitions:
  - IDLE: on `start` -> WGT. Counters are cleared.
  - WGT: `wgt_req`=1. On `wgt_ack` -> IFM.
  - IFM: `ifm_req`=1. On `ifm_ack` -> CMP.
  - CMP: `cmp_req`=1. On `cmp_ack`: if `tile_row` is odd -> ST, else -> NEXT.
  - ST: `st_req`=1. On `st_ack` -> NEXT.
  - NEXT: advance `tile_col`. When `tile_col` wraps, advance `tile_row`. When `tile_row` wraps, advance `filter_group`. If the group advanced and was not the last -> WGT. If the group was the last -> FIN. Otherwise -> IFM.
  - FIN: `done`=1 for one cycle -> IDLE.
- Pooling needs both rows of a pair. Odd OFM_SIZE: the final even row gets no store (floor pooling).
- Total compute handshakes per layer = NO_FG*OFM_SIZE*NO_TILING_PER_LINE.

## Timing
- All outputs are registered.
- Reset: state IDLE; all req, `done`, `busy` = 0; all coordinates = 0; `tile_width` = min(SYSTOLIC_SIZE, OFM_SIZE).
- Handshakes:
  - A req rises the cycle after entering its state and holds until the ack is sampled high.
  - A req falls in the cycle after that ack.
  - Ack is level-sampled only while its own req is high. An ack arriving with req low is ignored. An ack arriving in the same cycle req rises is also ignored, because req must already be registered high.
- Coordinates are stable from req rise through ack. They update only in NEXT.
- Minimum cost per tile: 2 cycles per handshake plus 1 cycle in NEXT.
- `start` while `busy` is ignored. `start` in the FIN cycle is ignored.
- `rst` mid-layer: on the next edge, return to reset values. No outstanding req survives.

## Structure
- Shared package `conv_cfg_pkg`: OFM_SIZE, OFM_SIZE_POOLING, NO_TILING_PER_LINE, NO_TILING, NO_FG as functions of the parameters; FSM state enum.
- One sub-module `tile_index_counter`: nested col/row/group counters with wrap flags and the `tile_width` computation. The FSM stays in the top.
- Estimated size: about 200 lines of RTL.

## Test plan
- Default parameters, all acks returned 1 cycle after req (responder) -> 1 `wgt`, 64 `ifm`, 64 `cmp`, 32 `st` handshakes. `done` pulses exactly once. The first tile is (0,0,0) and the last is row 31, col 1.
- IFM_SIZE=20 -> OFM 18, 2 tiles per line. Col 0 has `tile_width`=16 and col 1 has `tile_width`=2. 36 compute handshakes, 18 stores.
- NO_FILTER=40 -> NO_FG=3. `wgt_req` asserted 3 times, each before row 0 col 0 of its group. 192 compute handshakes.
- Acks with random 0-20 cycle delays, plus spurious acks while req is low -> handshake counts and coordinate sequence identical to the first test. The spurious acks have no effect.
- `start` pulsed during CMP, and again during FIN -> both ignored. Exactly one `done`.
- `rst` asserted during an ST handshake -> next cycle all req=0, `busy`=0, coordinates 0. A subsequent `start` runs a clean full layer.
